// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and width helpers for the iterative square root unit
//
// Purpose: defines the sequencing states, the rounding mode constants and the
// root/remainder width functions shared by the datapath and its bench.
// Ports: none (package).

package sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_NEAREST = 1;

    // Root width: half the radicand bits plus the requested fraction bits.
    function automatic int qw(input int width, input int frac);
        return width / 2 + frac;
    endfunction

    // Remainder width: one bit wider than the root, since r <= 2*q.
    function automatic int rw(input int width, input int frac);
        return qw(width, frac) + 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square root iteration
//
// Purpose: consumes the next two radicand bits and produces one more root bit.
// Ports:
//   i_r    [RW-1:0] working remainder before this step
//   i_q    [QW-1:0] partial root before this step
//   i_bits [1:0]    next two radicand bits, MSB first
//   o_r    [RW-1:0] working remainder after this step
//   o_q    [QW-1:0] partial root after this step

module sqrt_step #(
    parameter  int QW = 6,
    localparam int RW = QW + 1
) (
    input  logic [RW-1:0] i_r,
    input  logic [QW-1:0] i_q,
    input  logic [1:0]    i_bits,
    output logic [RW-1:0] o_r,
    output logic [QW-1:0] o_q
);

    logic [RW:0] w_r_shift;
    logic [RW:0] w_trial;
    logic [RW:0] w_diff;
    logic [QW:0] w_q_shift;
    logic        w_ge;
    logic        w_unused;

    // i_r never exceeds 2*q of the previous step, so its MSB is always zero
    // here and the shifted value fits RW+1 bits.
    assign w_r_shift = {i_r[RW-2:0], i_bits};
    assign w_trial   = {i_q, 2'b01};
    assign w_ge      = (w_r_shift >= w_trial);
    assign w_diff    = w_r_shift - w_trial;
    assign w_q_shift = {i_q, w_ge};

    // Both candidate remainders are bounded by 2*q_next and fit RW bits.
    assign o_r = w_ge ? w_diff[RW-1:0] : w_r_shift[RW-1:0];
    assign o_q = w_q_shift[QW-1:0];

    // Bits that are provably zero by the remainder bound above.
    assign w_unused = ^{i_r[RW-1], w_diff[RW], w_r_shift[RW], w_q_shift[QW]};

endmodule

// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - multi-cycle integer square root with start/ready/done handshake
//
// Purpose: computes Q = sqrt(A << 2*FRAC_BITS), one root bit per cycle, with
// optional round-to-nearest and saturation; results hold until the next done.
// Ports:
//   clk    clock, rising edge
//   rst_   asynchronous active-high reset
//   start  request, sampled only while ready
//   A      [WIDTH-1:0] unsigned radicand, captured on acceptance
//   ready  high in IDLE
//   busy   high in CALC and DONE
//   done   one-cycle pulse when Q/R/sat update
//   Q      [QW-1:0] root, FRAC_BITS fraction bits
//   R      [RW-1:0] remainder against the truncated root
//   sat    rounding would have overflowed Q

module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter  int WIDTH     = 12,
    parameter  int FRAC_BITS = 0,
    parameter  int ROUND     = 0,
    localparam int QW        = qw(WIDTH, FRAC_BITS),
    localparam int RW        = rw(WIDTH, FRAC_BITS)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    Q,
    output logic [RW-1:0]    R,
    output logic             sat
);

    localparam int RADW = 2 * QW;
    localparam int CW   = $clog2(QW + 1);

    state_t          r_state;
    logic [RADW-1:0] r_rad;
    logic [RW-1:0]   r_rem;
    logic [QW-1:0]   r_root;
    logic [CW-1:0]   r_cnt;
    logic [QW-1:0]   r_q;
    logic [RW-1:0]   r_r;
    logic            r_sat;

    logic [RADW-1:0] w_load;
    logic [RW-1:0]   w_r_next;
    logic [QW-1:0]   w_q_next;
    logic            w_round_up;
    logic            w_q_full;
    logic [QW-1:0]   w_q_final;
    logic            w_sat;

    // Radicand with the fraction zeros appended below it.
    assign w_load = RADW'(A) << (2 * FRAC_BITS);

    sqrt_step #(.QW(QW)) u_step (
        .i_r    (r_rem),
        .i_q    (r_root),
        .i_bits (r_rad[RADW-1 -: 2]),
        .o_r    (w_r_next),
        .o_q    (w_q_next)
    );

    // sqrt(x) >= q + 0.5  <=>  x >= q^2 + q + 0.25  <=>  r > q for integers.
    assign w_round_up = (ROUND == ROUND_NEAREST) && (w_r_next > {1'b0, w_q_next});
    assign w_q_full   = &w_q_next;
    assign w_q_final  = (w_round_up && !w_q_full) ? w_q_next + QW'(1) : w_q_next;
    assign w_sat      = w_round_up && w_q_full;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state <= ST_IDLE;
            r_rad   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rad   <= w_load;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CW'(QW - 1);
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem  <= w_r_next;
                    r_root <= w_q_next;
                    r_rad  <= r_rad << 2;
                    if (r_cnt == '0) begin
                        // Last step: publish results straight from the step outputs.
                        r_q     <= w_q_final;
                        r_r     <= w_r_next;
                        r_sat   <= w_sat;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign done  = (r_state == ST_DONE);
    assign Q     = r_q;
    assign R     = r_r;
    assign sat   = r_sat;

endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - directed self-checking bench for sqrt_iter

module tb_sqrt_iter;
    import sqrt_pkg::*;

    localparam int QW0 = qw(12, 0);
    localparam int RW0 = rw(12, 0);
    localparam int QW2 = qw(12, 2);
    localparam int RW2 = rw(12, 2);

    logic clk = 1'b0;
    logic rst_ = 1'b1;

    logic            st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [11:0]     a0 = '0, a1 = '0, a2 = '0;
    logic            rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
    logic            sat0, sat1, sat2;
    logic [QW0-1:0]  q0, q1;
    logic [RW0-1:0]  r0, r1;
    logic [QW2-1:0]  q2;
    logic [RW2-1:0]  r2;

    int n_pass  = 0;
    int n_total = 0;
    int sel     = 0;
    logic rdy_sel, dn_sel;

    always #5 clk = ~clk;

    assign rdy_sel = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    assign dn_sel  = (sel == 0) ? dn0  : (sel == 1) ? dn1  : dn2;

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(0), .ROUND(0)) u_dut0 (
        .clk(clk), .rst_(rst_), .start(st0), .A(a0), .ready(rdy0), .busy(bsy0),
        .done(dn0), .Q(q0), .R(r0), .sat(sat0));

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(0), .ROUND(1)) u_dut1 (
        .clk(clk), .rst_(rst_), .start(st1), .A(a1), .ready(rdy1), .busy(bsy1),
        .done(dn1), .Q(q1), .R(r1), .sat(sat1));

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(2), .ROUND(0)) u_dut2 (
        .clk(clk), .rst_(rst_), .start(st2), .A(a2), .ready(rdy2), .busy(bsy2),
        .done(dn2), .Q(q2), .R(r2), .sat(sat2));

    // Launches one op on the selected instance; returns the cycle (1 = first
    // cycle after the accepting edge) in which done was seen, and a timeout flag.
    task automatic run_op(input int which, input logic [11:0] a, output int cyc, output bit to);
        int k;
        sel = which;
        #0;
        k = 0;
        while (!rdy_sel && k < 50) begin
            @(posedge clk); #1; k++;
        end
        case (which)
            0: begin st0 = 1'b1; a0 = a; end
            1: begin st1 = 1'b1; a1 = a; end
            default: begin st2 = 1'b1; a2 = a; end
        endcase
        @(posedge clk); #1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        cyc = 1;
        while (!dn_sel && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        to = !dn_sel;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (rdy0 !== 1'b1) $display("FAIL rst_ready: got %b want 1", rdy0); else n_pass++;
        n_total++; if (bsy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", bsy0); else n_pass++;
        n_total++; if (dn0 !== 1'b0) $display("FAIL rst_done: got %b want 0", dn0); else n_pass++;
        n_total++; if (q0 !== 0 || r0 !== 0 || sat0 !== 1'b0)
            $display("FAIL rst_outputs: got Q=%0d R=%0d sat=%b want 0 0 0", q0, r0, sat0); else n_pass++;
        rst_ = 1'b0;
        @(posedge clk); #1;
        n_total++; if (rdy0 !== 1'b1 || dn0 !== 1'b0)
            $display("FAIL post_rst_idle: got ready=%b done=%b want 1 0", rdy0, dn0); else n_pass++;
    endtask

    task automatic test_basic();
        int cyc; bit to;
        run_op(0, 12'd256, cyc, to);
        n_total++; if (to || cyc != 7) $display("FAIL basic_latency: got %0d (timeout=%b) want 7", cyc, to); else n_pass++;
        n_total++; if (q0 !== 16 || r0 !== 0 || sat0 !== 1'b0)
            $display("FAIL basic_256: got Q=%0d R=%0d sat=%b want 16 0 0", q0, r0, sat0); else n_pass++;
        n_total++; if (bsy0 !== 1'b1 || rdy0 !== 1'b0)
            $display("FAIL done_flags: got busy=%b ready=%b want 1 0", bsy0, rdy0); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (dn0 !== 1'b0 || rdy0 !== 1'b1)
            $display("FAIL done_pulse: got done=%b ready=%b want 0 1", dn0, rdy0); else n_pass++;
    endtask

    task automatic test_hold();
        int cyc; bit to;
        run_op(0, 12'd4095, cyc, to);
        n_total++; if (to || q0 !== 63 || r0 !== 126)
            $display("FAIL max_4095: got Q=%0d R=%0d (timeout=%b) want 63 126", q0, r0, to); else n_pass++;
        @(posedge clk); #1;
        st0 = 1'b1; a0 = 12'd0;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bsy0 !== 1'b1 || q0 !== 63 || r0 !== 126)
            $display("FAIL hold_during_calc: got busy=%b Q=%0d R=%0d want 1 63 126", bsy0, q0, r0); else n_pass++;
        cyc = 0;
        while (!dn0 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        n_total++; if (!dn0 || q0 !== 0 || r0 !== 0)
            $display("FAIL zero: got done=%b Q=%0d R=%0d want 1 0 0", dn0, q0, r0); else n_pass++;
    endtask

    task automatic test_round();
        int cyc; bit to;
        run_op(1, 12'd72, cyc, to);
        n_total++; if (to || q1 !== 8 || r1 !== 8 || sat1 !== 1'b0)
            $display("FAIL round_72: got Q=%0d R=%0d sat=%b want 8 8 0", q1, r1, sat1); else n_pass++;
        run_op(1, 12'd73, cyc, to);
        n_total++; if (to || q1 !== 9 || r1 !== 9 || sat1 !== 1'b0)
            $display("FAIL round_73: got Q=%0d R=%0d sat=%b want 9 9 0", q1, r1, sat1); else n_pass++;
        run_op(1, 12'd4095, cyc, to);
        n_total++; if (to || q1 !== 63 || r1 !== 126 || sat1 !== 1'b1)
            $display("FAIL round_sat: got Q=%0d R=%0d sat=%b want 63 126 1", q1, r1, sat1); else n_pass++;
    endtask

    task automatic test_frac();
        int cyc; bit to;
        run_op(2, 12'd2, cyc, to);
        n_total++; if (to || cyc != 9) $display("FAIL frac_latency: got %0d (timeout=%b) want 9", cyc, to); else n_pass++;
        n_total++; if (q2 !== 5 || r2 !== 7 || sat2 !== 1'b0)
            $display("FAIL frac_2: got Q=%0d R=%0d sat=%b want 5 7 0", q2, r2, sat2); else n_pass++;
        run_op(2, 12'd4095, cyc, to);
        n_total++; if (to || q2 !== 255 || r2 !== 495)
            $display("FAIL frac_4095: got Q=%0d R=%0d want 255 495", q2, r2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int n_ready;
        bit overlap;
        bit bad_q;
        int k;
        k = 0;
        while (!rdy0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        n_ready = 0; overlap = 1'b0; bad_q = 1'b0;
        st0 = 1'b1; a0 = 12'd1000;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (dn0) begin
                dones.push_back(c);
                if (q0 !== 31 || r0 !== 39) bad_q = 1'b1;
            end
            if (rdy0) n_ready++;
            if (rdy0 && bsy0) overlap = 1'b1;
        end
        st0 = 1'b0;
        n_total++; if (dones.size() != 3) $display("FAIL b2b_count: got %0d want 3", dones.size()); else n_pass++;
        n_total++; if (dones.size() != 3 || dones[0] != 7 || dones[1] != 15 || dones[2] != 23)
            $display("FAIL b2b_spacing: got %p want '{7,15,23}", dones); else n_pass++;
        n_total++; if (n_ready != 3) $display("FAIL b2b_ready_cycles: got %0d want 3", n_ready); else n_pass++;
        n_total++; if (overlap || bad_q) $display("FAIL b2b_flags: got overlap=%b bad_q=%b want 0 0", overlap, bad_q); else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        int cyc; bit to;
        int n_done;
        int k;
        k = 0;
        while (!rdy0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        st0 = 1'b1; a0 = 12'd1000;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        #1;
        n_total++; if (q0 !== 0 || r0 !== 0 || sat0 !== 1'b0)
            $display("FAIL midrst_outputs: got Q=%0d R=%0d sat=%b want 0 0 0", q0, r0, sat0); else n_pass++;
        n_total++; if (rdy0 !== 1'b1 || bsy0 !== 1'b0 || dn0 !== 1'b0)
            $display("FAIL midrst_state: got ready=%b busy=%b done=%b want 1 0 0", rdy0, bsy0, dn0); else n_pass++;
        @(posedge clk); #1;
        rst_ = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (dn0 || bsy0) n_done++;
        end
        n_total++; if (n_done != 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", n_done); else n_pass++;
        run_op(0, 12'd1000, cyc, to);
        n_total++; if (to || cyc != 7 || q0 !== 31 || r0 !== 39)
            $display("FAIL after_rst_1000: got Q=%0d R=%0d cyc=%0d want 31 39 7", q0, r0, cyc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_round();
        test_frac();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
